// File: rtl/demultiplexor_pipe.sv
// ============================================================================
// demultiplexor_pipe
// ----------------------------------------------------------------------------
// Registered 1-to-2 demultiplexor. One valid/ready input stream is steered,
// word by word, into one of two single-entry output slots according to `sel`.
// Each slot has its own holding register, so the two consumers may stall
// independently. A stalled slot only back-pressures words aimed at it.
//
// Optional feature (compile-time macro DEMUX_STATS_EN):
//   When defined, adds per-port drain counters cnt0/cnt1 (CNT_WIDTH bits,
//   wrapping). When undefined, those ports and their logic are absent.
//
// Parameters:
//   WIDTH      data width of in_data / out0_data / out1_data
//   CNT_WIDTH  width of the drain counters (used only with DEMUX_STATS_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sel        destination of the current input word (0 -> out0, 1 -> out1)
//   in_valid   input word and sel are valid
//   in_ready   demux can accept the word this cycle (combinational)
//   in_data    input word
//   out0_valid slot 0 holds a word
//   out0_ready consumer 0 takes the word this cycle
//   out0_data  slot 0 word
//   out1_valid slot 1 holds a word
//   out1_ready consumer 1 takes the word this cycle
//   out1_data  slot 1 word
//   cnt0/cnt1  drains seen on out0/out1 (DEMUX_STATS_EN only)
// ============================================================================
module demultiplexor_pipe #(
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    // ------------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------------
    logic             slot0_valid_q, slot0_valid_d;
    logic             slot1_valid_q, slot1_valid_d;
    logic [WIDTH-1:0] slot0_data_q,  slot0_data_d;
    logic [WIDTH-1:0] slot1_data_q,  slot1_data_d;

    // Handshake decode
    logic slot0_room;
    logic slot1_room;
    logic accept;
    logic accept0;
    logic accept1;
    logic drain0;
    logic drain1;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    always_comb begin
        // A slot can take a word if it is empty, or if its current word
        // leaves this same cycle (keeps full throughput with ready held high).
        slot0_room = !slot0_valid_q || out0_ready;
        slot1_room = !slot1_valid_q || out1_ready;

        // Only the addressed slot matters; the other one may be stalled.
        in_ready   = sel ? slot1_room : slot0_room;

        accept     = in_valid && in_ready;
        accept0    = accept && !sel;
        accept1    = accept &&  sel;

        drain0     = slot0_valid_q && out0_ready;
        drain1     = slot1_valid_q && out1_ready;
    end

    // ------------------------------------------------------------------------
    // Next-state for both slots
    // ------------------------------------------------------------------------
    always_comb begin
        // Valid: set by an accept, cleared by a drain, an accept wins a tie.
        slot0_valid_d = accept0 || (slot0_valid_q && !out0_ready);
        slot1_valid_d = accept1 || (slot1_valid_q && !out1_ready);

        // Data registers load only on an accept into that slot, so the
        // output word is stable while a consumer stalls and keeps its last
        // value once the slot empties.
        slot0_data_d  = accept0 ? in_data : slot0_data_q;
        slot1_data_d  = accept1 ? in_data : slot1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
            slot0_data_q  <= '0;
            slot1_data_q  <= '0;
        end else begin
            slot0_valid_q <= slot0_valid_d;
            slot1_valid_q <= slot1_valid_d;
            slot0_data_q  <= slot0_data_d;
            slot1_data_q  <= slot1_data_d;
        end
    end

    assign out0_valid = slot0_valid_q;
    assign out1_valid = slot1_valid_q;
    assign out0_data  = slot0_data_q;
    assign out1_data  = slot1_data_q;

`ifdef DEMUX_STATS_EN
    // ------------------------------------------------------------------------
    // Drain counters (wrap naturally at 2^CNT_WIDTH)
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain0) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (drain1) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Drain strobes only feed the optional counters.
    logic unused_drain;
    assign unused_drain = drain0 ^ drain1;
`endif

endmodule

// File: tb/tb_demultiplexor_pipe.sv
// ============================================================================
// tb_demultiplexor_pipe
// Self-checking bench for demultiplexor_pipe (WIDTH=5, CNT_WIDTH=8).
// A behavioural model holds, per port, "is a word waiting and which one";
// a compare process checks every DUT output against it on each falling edge.
// Directed phases pin the model with literal expectations, then a random
// phase drives legal producer traffic and random consumer stalls.
// Build with +define+DEMUX_STATS_EN to also cover the drain counters.
// ============================================================================
module tb_demultiplexor_pipe;

    localparam int WIDTH     = 5;
    localparam int CNT_WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    demultiplexor_pipe #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: each port is a mailbox of at most one word.
    // ------------------------------------------------------------------------
    bit         m_full [2];
    bit [4:0]   m_word [2];
    int         m_cnt  [2];
    bit         m_last_acc;

    function automatic bit port_ready(input int p);
        return (p == 0) ? out0_ready : out1_ready;
    endfunction

    // The addressed mailbox can take a word if empty or being emptied now.
    function automatic bit model_in_ready();
        int p;
        p = sel ? 1 : 0;
        return !m_full[p] || port_ready(p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                m_full[p] = 0;
                m_word[p] = 0;
                m_cnt[p]  = 0;
            end
            m_last_acc = 0;
        end else begin
            bit acc;
            int dst;
            acc = in_valid && model_in_ready();
            dst = sel ? 1 : 0;
            for (int p = 0; p < 2; p++) begin
                bit took;
                took = m_full[p] && port_ready(p);
                if (took) m_cnt[p] = (m_cnt[p] + 1) % (1 << CNT_WIDTH);
                if (acc && dst == p) begin
                    m_full[p] = 1;
                    m_word[p] = in_data;
                end else if (took) begin
                    m_full[p] = 0;
                end
            end
            m_last_acc = acc;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("out0_valid", 32'(out0_valid), 32'(m_full[0]));
        check("out1_valid", 32'(out1_valid), 32'(m_full[1]));
        check("out0_data",  32'(out0_data),  32'(m_word[0]));
        check("out1_data",  32'(out1_data),  32'(m_word[1]));
        check("in_ready",   32'(in_ready),   32'(model_in_ready()));
`ifdef DEMUX_STATS_EN
        check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
    endtask

    initial begin
        // 1. Reset held with a pending request.
        send(1'b0, 5'h0E);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        step();
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data",  32'(out0_data),  32'h00);
        check("rst_out1_data",  32'(out1_data),  32'h00);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // 2. Single word to out0.
        send(1'b0, 5'h15);
        step();
        in_valid = 1'b0;
        check("t2_out0_valid", 32'(out0_valid), 32'd1);
        check("t2_out0_data",  32'(out0_data),  32'h15);
        check("t2_out1_valid", 32'(out1_valid), 32'd0);
        step();
        check("t2_out0_empty", 32'(out0_valid), 32'd0);
        check("t2_out0_hold",  32'(out0_data),  32'h15);

        // 3. Single word to out1; out0 data untouched.
        send(1'b1, 5'h0A);
        step();
        in_valid = 1'b0;
        check("t3_out1_valid", 32'(out1_valid), 32'd1);
        check("t3_out1_data",  32'(out1_data),  32'h0A);
        check("t3_out0_data",  32'(out0_data),  32'h15);
        step();

        // 4. Stalled out0 blocks only traffic for out0.
        out0_ready = 1'b0;
        send(1'b0, 5'h15);
        step();
        send(1'b0, 5'h0A);
        #1;
        check("t4_in_ready_blk", 32'(in_ready),  32'd0);
        step();
        check("t4_out0_held",    32'(out0_data), 32'h15);
        check("t4_out0_valid",   32'(out0_valid), 32'd1);
        send(1'b1, 5'h1F);
        #1;
        check("t4_in_ready_s1",  32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        check("t4_out1_data",    32'(out1_data), 32'h1F);
        check("t4_out1_valid",   32'(out1_valid), 32'd1);
        check("t4_out0_still",   32'(out0_data), 32'h15);
        out0_ready = 1'b1;
        step();
        step();

        // 5. Back-to-back alternating words, one accept per cycle.
        for (int k = 0; k < 8; k++) begin
            logic [WIDTH-1:0] w;
            w = WIDTH'(k * 3 + 1);
            send(k[0], w);
            #1;
            check("t5_in_ready", 32'(in_ready), 32'd1);
            step();
            if (k[0]) check("t5_out1_data", 32'(out1_data), 32'(w));
            else      check("t5_out0_data", 32'(out0_data), 32'(w));
        end
        in_valid = 1'b0;
        step();

        // 6. Reset while both slots are full drops valids immediately.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 5'h07);
        step();
        send(1'b1, 5'h09);
        step();
        in_valid = 1'b0;
        check("t6_both_full", 32'({out0_valid, out1_valid}), 32'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valids", 32'({out0_valid, out1_valid}), 32'b00);
        check("t6_rst_data0",  32'(out0_data), 32'h00);
        step();
        rst_n = 1'b1;
        step();

`ifdef DEMUX_STATS_EN
        // Counter wrap: 256 drains on out0.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            send(1'b0, WIDTH'($urandom));
            step();
        end
        in_valid = 1'b0;
        check("cnt0_pre_wrap", 32'(cnt0), 32'd255);
        step();
        check("cnt0_wrap", 32'(cnt0), 32'd0);
        check("cnt1_idle", 32'(cnt1), 32'd0);
`endif

        // Random phase: legal producer (holds until accepted), random stalls.
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || m_last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel      = 1'($urandom);
                in_data  = WIDTH'($urandom);
            end
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 4) == 0);
            if (i > 1500) out1_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/demultiplexor_pipe.md
Name: demultiplexor_pipe

Overview:
- Registered 1-to-2 demultiplexor, the inverse of the team's parameterised 2:1 `multiplexor`.
- Takes one valid/ready input stream and steers each accepted word to output port 0 or 1 according to `sel`.
- Each output has a one-entry holding register, so the two downstream consumers can stall independently without corrupting data.
- Sits between a single producer and two consumers, e.g. splitting a command stream across two units.

Parameters:
- WIDTH, 5, data width in bits of `in_data`, `out0_data` and `out1_data`.
- CNT_WIDTH, 8, width of the transfer counters; only used when DEMUX_STATS_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sel  input  1  destination of the current input word: 0 selects out0, 1 selects out1.
- in_valid  input  1  `in_data` and `sel` are valid this cycle.
- in_ready  output  1  the demux can accept the word this cycle.
- in_data  input  WIDTH  input word.
- out0_valid  output  1  slot 0 holds a word.
- out0_ready  input  1  consumer 0 takes the word this cycle.
- out0_data  output  WIDTH  slot 0 word.
- out1_valid  output  1  slot 1 holds a word.
- out1_ready  input  1  consumer 1 takes the word this cycle.
- out1_data  output  WIDTH  slot 1 word.
- cnt0, cnt1  output  CNT_WIDTH  only present with DEMUX_STATS_EN; see Optional Feature.

Behaviour:
- Reset: while rst_n=0, asynchronously force out0_valid=0, out1_valid=0, out0_data=0, out1_data=0 (and cnt0=cnt1=0 when counters are present). Deasserting reset starts normal operation on the next rising edge.
- Slot state per output X: EMPTY (outX_valid=0) or FULL (outX_valid=1).
  - EMPTY -> FULL on an accept with sel=X.
  - FULL -> EMPTY when outX_ready=1 and there is no same-cycle accept with sel=X.
  - FULL -> FULL with new data when outX_ready=1 and an accept with sel=X occur in the same cycle.
  - FULL -> FULL, data held, when outX_ready=0.
- in_ready (combinational):
  - sel=0: in_ready = !out0_valid | out0_ready.
  - sel=1: in_ready = !out1_valid | out1_ready.
  - The non-selected slot has no influence on in_ready.
- Accept: in_valid & in_ready at a rising edge. The word is captured into the selected slot. Latency is 1 cycle: the word appears on outX_data with outX_valid=1 from the next cycle.
- Drain: outX_valid & outX_ready at a rising edge.
- Output stability: while outX_valid=1 and outX_ready=0, outX_data must not change.
- Data registers load only on an accept to that slot. outX_data holds its last value when the slot is EMPTY.
- Independence: a stalled out0 never blocks traffic to out1, and vice versa. Both slots may be FULL at once.
- Throughput: one word per cycle sustained to a port whose consumer holds ready=1.
- sel and in_data are don't-care when in_valid=0. in_ready may still toggle with sel; the producer must not depend on that.
- Producer rule: once in_valid=1, in_valid, sel and in_data are held until accepted. The block does not check this rule.
- Reset mid-operation: pending words in either slot are discarded. No partial transfer may appear after reset.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds output ports cnt0 and cnt1, each CNT_WIDTH bits wide.
  - cntX increments by 1 on every drain of slot X and wraps from 2^CNT_WIDTH-1 to 0.
  - Both counters reset to 0 asynchronously.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan (WIDTH=5, CNT_WIDTH=8):
1. Reset held with in_valid=1 -> in_ready=1, out0_valid=out1_valid=0, out0_data=out1_data=5'h00.
2. Single word, sel=0, in_data=5'h15, out0_ready=1 -> the next cycle shows out0_valid=1, out0_data=5'h15, out1_valid=0; the slot empties after one cycle.
3. Single word, sel=1, in_data=5'h0A -> out1_data=5'h0A after 1 cycle; out0_data is unchanged.
4. out0_ready=0, send 5'h15 to out0 and then 5'h0A (sel=0):
   - in_ready=0 for the second word and out0_data holds 5'h15.
   - Meanwhile 5'h1F with sel=1 is accepted and delivered on out1.
5. Both ports with ready=1, 8 back-to-back words with alternating sel -> one accept per cycle; each word arrives in order on its port 1 cycle after its accept.
6. Reset asserted while both slots are FULL -> both valids drop immediately. With DEMUX_STATS_EN, 256 drains on out0 wrap cnt0 to 0.
